// File: rtl/ex_div_pkg.sv
// Shared encodings for the execute-stage divider: FSM states, handshake levels
// and the DIV/DIVU aluop codes decoded by EX.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// Restoring 32-bit DIV/DIVU: result 33 cycles after start (1 cycle for /0); start_i is
// held by EX until ready_o, result holds until start_i drops; annul_i aborts an active divide.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;

    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   rem_d;
    logic [DATA_W-1:0]   quo_d;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_abs = op1_neg ? negate(opdata1_i) : opdata1_i;
        op2_abs = op2_neg ? negate(opdata2_i) : opdata2_i;
    end

    // The partial remainder is kept at full width so divisors above 2^31 still work;
    // the borrow of the 33-bit subtract decides whether this quotient bit is set.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = shifted[DATA_W-1:0];
        quo_d   = {quo_q[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W]) begin
            rem_d    = diff[DATA_W-1:0];
            quo_d[0] = 1'b1;
        end
        quo_fix = neg_quo_q ? negate(quo_q) : quo_q;
        rem_fix = neg_rem_q ? negate(rem_q) : rem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q   <= DivOn;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= op1_abs;
                            dvs_q     <= op2_abs;
                            neg_quo_q <= op1_neg ^ op2_neg;
                            neg_rem_q <= op1_neg;
                        end
                    end
                end
                DivByZero: begin
                    state_q  <= DivEnd;
                    result_q <= '0;
                    ready_q  <= DivResultReady;
                end
                DivOn: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                    end else if (cnt_q != CNT_W'(DATA_W)) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        state_q  <= DivEnd;
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_q  <= DivFree;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == DivOn) || (state_q == DivByZero);

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed vector table, flush/reset sequences, random ops vs arithmetic model.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    ex_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
        end
    endtask

    // Reference: truncating division as plain 64-bit arithmetic; quotient wraps to 32 bits.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int n;
        logic [63:0] res;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        n = 0;
        chk({tag, ".busy_after_start"}, 64'(busy_o), 64'd1);
        chk({tag, ".ready_early"}, 64'(ready_o), 64'd0);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ".result"}, result_o, exp);
        chk({tag, ".busy_at_ready"}, 64'(busy_o), 64'd0);
        res = result_o;
        tick();
        chk({tag, ".hold"}, {ready_o, res}, {1'b1, exp});
        start_i = 1'b0;
        tick();
        chk({tag, ".drop"}, {ready_o, result_o}, 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33};
        vecs[4] = '{1'b0, 32'h12345678,   32'h00000000,   64'h0,                 1};
        vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'h80000001,   64'h7FFFFFFE_00000001, 33};
        vecs[8] = '{1'b1, 32'h00000003,   32'h00000000,   64'h0,                 1};

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        chk("reset_outputs", {result_o[62:0], ready_o}, 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Flush mid-divide, then a fresh divide on the very next cycle.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd20;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        chk("annul.state", {62'd0, busy_o, ready_o}, 64'd0);
        run_op("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // start held together with annul in FREE must not launch anything.
        annul_i   = 1'b1;
        start_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        tick();
        chk("annul_in_free", 64'(busy_o), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();

        // Asynchronous reset in the middle of ON.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        start_i   = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_on", {result_o[61:0], busy_o, ready_o}, 64'd0);
        start_i = 1'b0;
        #3 rst = 1'b1;
        tick();
        run_op("after_rst", 1'b0, 32'd1000, 32'd9, 64'h00000001_0000006F, 33);

        // Asynchronous reset while a result is being held.
        opdata1_i = 32'd77;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        tick();
        opdata1_i = 32'd77;
        opdata2_i = 32'd10;
        signed_div_i = 1'b0;
        tick();
        tick();
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        for (int i = 0; i < 34; i++) tick();
        chk("end_before_rst", {ready_o, result_o}, {1'b1, 64'h00000007_00000007});
        #3 rst = 1'b0;
        #1;
        chk("async_rst_end", {result_o[62:0], ready_o}, 64'd0);
        start_i = 1'b0;
        #2 rst = 1'b1;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          mode;
            s    = 1'($urandom_range(0, 1));
            a    = (i % 7 == 3) ? 32'h80000000 : $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                default: b = 32'hFFFFFFFF - $urandom_range(0, 15);
            endcase
            run_op($sformatf("rand%0d", i), s, a, b, model(s, a, b), (b == 0) ? 1 : 33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
Multi-cycle 32-bit integer divider for the execute stage, directly downstream of the ID/EX pipeline register. The EX stage decodes DIV/DIVU from the aluop it receives and drives this unit with the two register operands. While the divide is in flight, EX holds the pipeline stalled. The result returns as a 64-bit {remainder, quotient} pair for the HI/LO write.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W
- CNT_W, 6, iteration counter width; must hold the value DATA_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- signed_div_i  in  1  1 = signed DIV, 0 = unsigned DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; EX holds it high until ready_o is seen
- annul_i  in  1  cancel an in-flight divide (pipeline flush)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid
- busy_o  out  1  high in states ON and BYZERO

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, busy_o=0. Reset mid-divide aborts the operation immediately.
- State FREE:
  - Ignores start_i when annul_i=1.
  - start_i=1 with opdata2_i==0 -> BYZERO.
  - start_i=1 otherwise -> ON. At this transition, latch the sign info and the absolute values of both operands. Operands are two's-complement negated only when signed_div_i=1 and the operand's MSB is 1. Clear the remainder register; cnt=0.
- State BYZERO: next edge -> END with result=0.
- State ON:
  - annul_i=1 -> FREE with no result; ready_o stays 0.
  - cnt<32, one restoring step per cycle:
    - rem = {rem[30:0], q[31]}; q <<= 1.
    - Compare using a 33-bit subtract. If rem >= divisor: rem -= divisor and q[0] = 1.
    - cnt++.
  - cnt==32, sign fix-up, then -> END:
    - Signed: negate the quotient if the dividend and divisor signs differ.
    - Signed: negate the remainder if the dividend is negative.
    - Latch {rem, q} into result_o and set ready_o=1.
- State END: result_o and ready_o hold while start_i=1. When start_i=0 -> FREE, ready_o=0, result_o=0.
- Latency:
  - Start sampled at edge E0 gives ready_o=1 after edge E33 (33 cycles).
  - Divide-by-zero gives ready_o=1 after E1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- Operand changes after the start edge have no effect; only latched copies are used.
- annul_i in BYZERO or END is ignored. The flush logic in EX deasserts start_i instead.

Decomposition:
- Shared defines file holds:
  - State encodings: DivFree, DivByZero, DivOn, DivEnd.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - The DIV/DIVU aluop codes already used by EX.
- No sub-module. One FSM plus datapath in a single module; the negation is a local function.

Test Plan:
- Unsigned 100/7, start held -> ready_o high exactly 33 cycles after the start edge; result_o = 0x00000002_0000000E. Drop start_i -> ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (any dividend / 0) -> ready_o after 1 cycle, result_o = 0, busy_o high for one cycle.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- annul_i pulsed 10 cycles into ON -> state FREE and ready_o never asserts. A new 9/3 start on the following cycle completes with 0x00000000_00000003.
- Assert rst=0 asynchronously, between clock edges, during ON -> ready_o, busy_o and result_o go to 0 without a clock edge. After release, a new divide runs the full 33 cycles.
